soc_decerr_responder: RTL and testbench
=======================================

SOC_DECERR_RESPONDER -- requirements
Module: soc_decerr_responder

Interface
REQ-001 SHALL have parameter IdWidth, default 6 (slave-side ID: 4 + clog2(4 masters)), meaning AXI ID width.
REQ-002 SHALL have parameter DataWidth, default 64, meaning R data width.
REQ-003 SHALL have parameter RespData, default 64'hBADC_AB1E_BADC_AB1E, meaning RDATA returned on every read beat.
REQ-004 clk_i  input  1  single clock; all logic rising-edge.
REQ-005 rst_i  input  1  asynchronous, active-high reset.
REQ-006 aw_valid_i/aw_ready_o  in/out  1  AW handshake; aw_id_i in IdWidth; aw_len_i in 8.
REQ-007 w_valid_i/w_ready_o  in/out  1  W handshake; w_last_i in 1; W data/strb ignored, not ported.
REQ-008 b_valid_o/b_ready_i  out/in  1  B handshake; b_id_o out IdWidth; b_resp_o out 2.
REQ-009 ar_valid_i/ar_ready_o  in/out  1  AR handshake; ar_id_i in IdWidth; ar_len_i in 8.
REQ-010 r_valid_o/r_ready_i  out/in  1  R handshake; r_id_o out IdWidth; r_data_o out DataWidth; r_resp_o out 2; r_last_o out 1.
REQ-011 err_valid_o out 1, err_is_write_o out 1, err_id_o out IdWidth, err_clr_i in 1  first-error capture (see Configuration).

Function
REQ-012 SHALL terminate every transaction the crossbar cannot map to a slave region, answering DECERR (2'b11) on every B and R beat.
REQ-013 Write FSM states W_IDLE, W_DATA, W_RESP; aw_ready_o = 1 only in W_IDLE.
REQ-014 AW handshake in W_IDLE: latch aw_id_i, go W_DATA next cycle.
REQ-015 W_DATA: w_ready_o = 1; every beat consumed; beat with w_last_i = 1 moves to W_RESP; aw_len_i not checked against W beat count.
REQ-016 W_RESP: b_valid_o = 1, b_id_o = latched ID, held stable until b_ready_i; handshake returns to W_IDLE (new AW accepted no earlier than next cycle).
REQ-017 Read FSM states R_IDLE, R_DATA; ar_ready_o = 1 only in R_IDLE.
REQ-018 AR handshake: latch ar_id_i, load 8-bit beat counter with ar_len_i, go R_DATA.
REQ-019 R_DATA: r_valid_o = 1, r_data_o = RespData, r_id_o = latched ID; r_last_o = 1 iff counter = 0; each handshake decrements counter; handshake with r_last_o returns to R_IDLE.
REQ-020 ar_len_i = 255 SHALL yield exactly 256 beats; ar_len_i = 0 exactly one beat with r_last_o = 1.
REQ-021 Read and write FSMs independent; simultaneous AW and AR both accepted same cycle.
REQ-022 At most one write and one read outstanding; no ID reordering.
REQ-023 Output valid/data SHALL NOT change while valid high and ready low.
REQ-024 Latency: first R beat / B earliest one cycle after the enabling handshake (AR, last W).

Reset
REQ-025 rst_i asserted at any time SHALL force W_IDLE, R_IDLE, counter 0, latched IDs 0, err_* 0, in-flight transactions dropped.
REQ-026 Reset outputs: aw_ready_o = 1, ar_ready_o = 1, w_ready_o = 0, b_valid_o = 0, r_valid_o = 0, r_last_o = 0, b_resp_o = r_resp_o = 2'b11, r_data_o = RespData, b_id_o = r_id_o = 0.

Configuration
REQ-027 Macro DECERR_CAPTURE_EN defined: on first AW or AR handshake while err_valid_o = 0, capture err_is_write_o (1 = AW) and err_id_o, set err_valid_o; hold until err_clr_i; simultaneous AW and AR captures AW; err_clr_i with new handshake same cycle: clear wins.
REQ-028 Macro undefined: err_valid_o, err_is_write_o, err_id_o tied 0; err_clr_i ignored; no capture registers.

Structure
REQ-029 State enums (w_state_e, r_state_e) and DECERR encoding constant SHALL reside in shared package soc_decerr_pkg; IdWidth default derived from SoC package IdWidthSlave.
REQ-030 Single module, no sub-module; optional capture logic inline.

Verification
REQ-031 AR id=5 len=3, r_ready_i = 1 -> 4 R beats, r_id 5, resp 2'b11, data RespData, r_last_o on 4th only.
REQ-032 AW id=2 len=1 + 2 W beats (last on 2nd), b_ready_i low 5 cycles -> b_valid_o held, b_id 2, resp 2'b11, ends after ready.
REQ-033 Same-cycle AW id=1 and AR id=3 len=0 -> both accepted; B id 1 and single R id 3 r_last_o = 1.
REQ-034 AR len=255 with random r_ready_i -> exactly 256 beats, counter wrap absent, r_data_o stable under stall.
REQ-035 rst_i pulsed mid-read (beat 2 of 8) -> next cycle r_valid_o = 0, ar_ready_o = 1; new AR served normally.
REQ-036 DECERR_CAPTURE_EN: AR id=7 then AW id=4 -> err_valid_o = 1, err_id_o = 7, err_is_write_o = 0; err_clr_i -> all 0.

Source files
------------

// File: rtl/soc_decerr_pkg.sv
// Shared types and constants for the SoC default (decode-error) slave.
// IdWidthSlave mirrors the SoC-level slave-side ID width: 4 master ID bits + clog2(4 masters).
package soc_decerr_pkg;

  localparam int unsigned NumMasters   = 4;
  localparam int unsigned IdWidthMst   = 4;
  localparam int unsigned IdWidthSlave = IdWidthMst + $clog2(NumMasters);

  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_e;

endpackage

// File: rtl/soc_decerr_responder.sv
// AXI default slave: terminates unmapped transactions with DECERR on every B and R beat.
// Optional first-error capture is built only when DECERR_CAPTURE_EN is defined.
module soc_decerr_responder
  import soc_decerr_pkg::*;
#(
  parameter int unsigned             IdWidth   = IdWidthSlave,
  parameter int unsigned             DataWidth = 64,
  parameter logic [DataWidth-1:0]    RespData  = DataWidth'(64'hBADC_AB1E_BADC_AB1E)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,

  input  logic                 aw_valid_i,
  output logic                 aw_ready_o,
  input  logic [IdWidth-1:0]   aw_id_i,
  input  logic [7:0]           aw_len_i,

  input  logic                 w_valid_i,
  output logic                 w_ready_o,
  input  logic                 w_last_i,

  output logic                 b_valid_o,
  input  logic                 b_ready_i,
  output logic [IdWidth-1:0]   b_id_o,
  output logic [1:0]           b_resp_o,

  input  logic                 ar_valid_i,
  output logic                 ar_ready_o,
  input  logic [IdWidth-1:0]   ar_id_i,
  input  logic [7:0]           ar_len_i,

  output logic                 r_valid_o,
  input  logic                 r_ready_i,
  output logic [IdWidth-1:0]   r_id_o,
  output logic [DataWidth-1:0] r_data_o,
  output logic [1:0]           r_resp_o,
  output logic                 r_last_o,

  output logic                 err_valid_o,
  output logic                 err_is_write_o,
  output logic [IdWidth-1:0]   err_id_o,
  input  logic                 err_clr_i
);

  w_state_e           w_state_q, w_state_d;
  r_state_e           r_state_q, r_state_d;
  logic [IdWidth-1:0] b_id_q;
  logic [IdWidth-1:0] r_id_q;
  logic [7:0]         r_cnt_q;

  logic aw_hs, ar_hs, r_hs;

  // Burst length is never compared with the W beat count; only w_last_i ends a write.
  logic unused_aw_len;
  assign unused_aw_len = ^aw_len_i;

  assign aw_hs = aw_valid_i & aw_ready_o;
  assign ar_hs = ar_valid_i & ar_ready_o;
  assign r_hs  = r_valid_o & r_ready_i;

  // ---------------- write channel ----------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      w_state_q <= W_IDLE;
      b_id_q    <= '0;
    end else begin
      w_state_q <= w_state_d;
      if (aw_hs) b_id_q <= aw_id_i;
    end
  end

  always_comb begin
    w_state_d  = w_state_q;
    aw_ready_o = 1'b0;
    w_ready_o  = 1'b0;
    b_valid_o  = 1'b0;
    unique case (w_state_q)
      W_IDLE: begin
        aw_ready_o = 1'b1;
        if (aw_valid_i) w_state_d = W_DATA;
      end
      W_DATA: begin
        w_ready_o = 1'b1;
        if (w_valid_i && w_last_i) w_state_d = W_RESP;
      end
      W_RESP: begin
        b_valid_o = 1'b1;
        if (b_ready_i) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  assign b_id_o   = b_id_q;
  assign b_resp_o = RESP_DECERR;

  // ---------------- read channel ----------------
  // r_cnt_q holds the remaining beats after the current one, so it never wraps.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state_q <= R_IDLE;
      r_id_q    <= '0;
      r_cnt_q   <= '0;
    end else begin
      r_state_q <= r_state_d;
      if (ar_hs) begin
        r_id_q  <= ar_id_i;
        r_cnt_q <= ar_len_i;
      end else if (r_hs && !r_last_o) begin
        r_cnt_q <= r_cnt_q - 8'd1;
      end
    end
  end

  always_comb begin
    r_state_d  = r_state_q;
    ar_ready_o = 1'b0;
    r_valid_o  = 1'b0;
    r_last_o   = 1'b0;
    unique case (r_state_q)
      R_IDLE: begin
        ar_ready_o = 1'b1;
        if (ar_valid_i) r_state_d = R_DATA;
      end
      R_DATA: begin
        r_valid_o = 1'b1;
        r_last_o  = (r_cnt_q == 8'd0);
        if (r_ready_i && r_last_o) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  assign r_id_o   = r_id_q;
  assign r_data_o = RespData;
  assign r_resp_o = RESP_DECERR;

  // ---------------- first-error capture ----------------
`ifdef DECERR_CAPTURE_EN
  logic               err_valid_q;
  logic               err_is_write_q;
  logic [IdWidth-1:0] err_id_q;

  // Clear beats a same-cycle handshake; AW takes priority over AR.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_valid_q    <= 1'b0;
      err_is_write_q <= 1'b0;
      err_id_q       <= '0;
    end else if (err_clr_i) begin
      err_valid_q    <= 1'b0;
      err_is_write_q <= 1'b0;
      err_id_q       <= '0;
    end else if (!err_valid_q && aw_hs) begin
      err_valid_q    <= 1'b1;
      err_is_write_q <= 1'b1;
      err_id_q       <= aw_id_i;
    end else if (!err_valid_q && ar_hs) begin
      err_valid_q    <= 1'b1;
      err_is_write_q <= 1'b0;
      err_id_q       <= ar_id_i;
    end
  end

  assign err_valid_o    = err_valid_q;
  assign err_is_write_o = err_is_write_q;
  assign err_id_o       = err_id_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr_i;

  assign err_valid_o    = 1'b0;
  assign err_is_write_o = 1'b0;
  assign err_id_o       = '0;
`endif

endmodule

// File: tb/tb_soc_decerr_responder.sv
// Directed bench for soc_decerr_responder; inputs change and outputs are sampled on the falling edge.
// Capture checks follow DECERR_CAPTURE_EN; otherwise the err_* outputs must stay at 0.
module tb_soc_decerr_responder;

  localparam int unsigned IdW = 6;
  localparam int unsigned DW  = 64;
  localparam logic [63:0] RD  = 64'hBADC_AB1E_BADC_AB1E;

  logic           clk = 1'b0;
  logic           rst;
  logic           aw_valid, aw_ready;
  logic [IdW-1:0] aw_id;
  logic [7:0]     aw_len;
  logic           w_valid, w_ready, w_last;
  logic           b_valid, b_ready;
  logic [IdW-1:0] b_id;
  logic [1:0]     b_resp;
  logic           ar_valid, ar_ready;
  logic [IdW-1:0] ar_id;
  logic [7:0]     ar_len;
  logic           r_valid, r_ready, r_last;
  logic [IdW-1:0] r_id;
  logic [DW-1:0]  r_data;
  logic [1:0]     r_resp;
  logic           err_valid, err_is_write, err_clr;
  logic [IdW-1:0] err_id;

  int vectors = 0;
  int errs    = 0;

  soc_decerr_responder dut (
    .clk_i(clk), .rst_i(rst),
    .aw_valid_i(aw_valid), .aw_ready_o(aw_ready), .aw_id_i(aw_id), .aw_len_i(aw_len),
    .w_valid_i(w_valid), .w_ready_o(w_ready), .w_last_i(w_last),
    .b_valid_o(b_valid), .b_ready_i(b_ready), .b_id_o(b_id), .b_resp_o(b_resp),
    .ar_valid_i(ar_valid), .ar_ready_o(ar_ready), .ar_id_i(ar_id), .ar_len_i(ar_len),
    .r_valid_o(r_valid), .r_ready_i(r_ready), .r_id_o(r_id), .r_data_o(r_data),
    .r_resp_o(r_resp), .r_last_o(r_last),
    .err_valid_o(err_valid), .err_is_write_o(err_is_write), .err_id_o(err_id),
    .err_clr_i(err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // Drains a read burst with r_ready held high; checks every beat and the total count.
  task automatic read_burst(input string tag, input logic [IdW-1:0] id, input int len);
    int beats = 0;
    int cyc   = 0;
    r_ready = 1'b1;
    while (beats < len + 1 && cyc < 600) begin
      if (r_valid) begin
        chk({tag, "_rid"},  64'(r_id),   64'(id));
        chk({tag, "_resp"}, 64'(r_resp), 64'd3);
        chk({tag, "_data"}, r_data,      RD);
        chk({tag, "_last"}, 64'(r_last), 64'(beats == len));
        beats++;
      end
      cyc++;
      step();
    end
    chk({tag, "_beats"}, 64'(beats), 64'(len + 1));
    chk({tag, "_idle_rvalid"}, 64'(r_valid), 64'd0);
    chk({tag, "_idle_arready"}, 64'(ar_ready), 64'd1);
  endtask

  initial begin
    logic [DW-1:0] held_data;
    logic          held_last;
    logic          stalled;
    int            beats;
    int            cyc;

    rst = 1'b1;
    aw_valid = 0; aw_id = '0; aw_len = '0;
    w_valid = 0; w_last = 0; b_ready = 0;
    ar_valid = 0; ar_id = '0; ar_len = '0;
    r_ready = 0; err_clr = 0;

    // Reset state
    step();
    chk("rst_aw_ready", 64'(aw_ready), 64'd1);
    chk("rst_ar_ready", 64'(ar_ready), 64'd1);
    chk("rst_w_ready",  64'(w_ready),  64'd0);
    chk("rst_b_valid",  64'(b_valid),  64'd0);
    chk("rst_r_valid",  64'(r_valid),  64'd0);
    chk("rst_r_last",   64'(r_last),   64'd0);
    chk("rst_b_resp",   64'(b_resp),   64'd3);
    chk("rst_r_resp",   64'(r_resp),   64'd3);
    chk("rst_r_data",   r_data,        RD);
    chk("rst_b_id",     64'(b_id),     64'd0);
    chk("rst_r_id",     64'(r_id),     64'd0);
    chk("rst_err_valid", 64'(err_valid), 64'd0);
    rst = 1'b0;
    step();

    // AR id=5 len=3: four beats, last on the fourth
    ar_valid = 1; ar_id = 6'd5; ar_len = 8'd3;
    step();
    ar_valid = 0;
    chk("ar5_ar_ready_busy", 64'(ar_ready), 64'd0);
    read_burst("ar5", 6'd5, 3);
    r_ready = 0;

    // AW id=2 len=1, two W beats, B stalled 5 cycles
    aw_valid = 1; aw_id = 6'd2; aw_len = 8'd1;
    step();
    aw_valid = 0;
    chk("aw2_w_ready", 64'(w_ready), 64'd1);
    chk("aw2_aw_ready_busy", 64'(aw_ready), 64'd0);
    chk("aw2_b_valid_early", 64'(b_valid), 64'd0);
    w_valid = 1; w_last = 0;
    step();
    chk("aw2_b_valid_mid", 64'(b_valid), 64'd0);
    w_last = 1;
    step();
    w_valid = 0; w_last = 0;
    for (int i = 0; i < 5; i++) begin
      chk("aw2_b_valid_hold", 64'(b_valid), 64'd1);
      chk("aw2_b_id", 64'(b_id), 64'd2);
      chk("aw2_b_resp", 64'(b_resp), 64'd3);
      chk("aw2_w_ready_off", 64'(w_ready), 64'd0);
      step();
    end
    b_ready = 1;
    step();
    b_ready = 0;
    chk("aw2_b_done", 64'(b_valid), 64'd0);
    chk("aw2_aw_ready_back", 64'(aw_ready), 64'd1);

    // Simultaneous AW id=1 and AR id=3 len=0
    aw_valid = 1; aw_id = 6'd1; aw_len = 8'd0;
    ar_valid = 1; ar_id = 6'd3; ar_len = 8'd0;
    chk("sim_aw_ready", 64'(aw_ready), 64'd1);
    chk("sim_ar_ready", 64'(ar_ready), 64'd1);
    step();
    aw_valid = 0; ar_valid = 0;
    chk("sim_w_ready", 64'(w_ready), 64'd1);
    chk("sim_r_valid", 64'(r_valid), 64'd1);
    chk("sim_r_id",    64'(r_id),    64'd3);
    chk("sim_r_last",  64'(r_last),  64'd1);
    w_valid = 1; w_last = 1;
    step();
    w_valid = 0; w_last = 0;
    chk("sim_b_valid", 64'(b_valid), 64'd1);
    chk("sim_b_id",    64'(b_id),    64'd1);
    chk("sim_r_still", 64'(r_valid), 64'd1);
    b_ready = 1; r_ready = 1;
    step();
    b_ready = 0; r_ready = 0;
    chk("sim_b_done", 64'(b_valid), 64'd0);
    chk("sim_r_done", 64'(r_valid), 64'd0);

    // AR len=255 with random r_ready: 256 beats, stable under stall
    ar_valid = 1; ar_id = 6'd9; ar_len = 8'd255;
    step();
    ar_valid = 0;
    beats = 0; cyc = 0; stalled = 0; held_data = '0; held_last = 0;
    while (beats < 256 && cyc < 4000) begin
      chk("long_r_valid", 64'(r_valid), 64'd1);
      if (stalled) begin
        chk("long_stall_data", r_data, 64'(held_data));
        chk("long_stall_last", 64'(r_last), 64'(held_last));
      end
      chk("long_r_last", 64'(r_last), 64'(beats == 255));
      chk("long_r_id", 64'(r_id), 64'd9);
      r_ready = 1'($urandom_range(0, 1));
      held_data = r_data; held_last = r_last;
      stalled = !r_ready;
      if (r_ready) beats++;
      cyc++;
      step();
    end
    r_ready = 0;
    chk("long_beats", 64'(beats), 64'd256);
    chk("long_r_valid_end", 64'(r_valid), 64'd0);
    chk("long_ar_ready_end", 64'(ar_ready), 64'd1);

    // Reset pulsed at beat 2 of an 8-beat read
    ar_valid = 1; ar_id = 6'd6; ar_len = 8'd7;
    step();
    ar_valid = 0;
    r_ready = 1;
    step();
    step();
    chk("rstmid_r_valid_pre", 64'(r_valid), 64'd1);
    chk("rstmid_r_last_pre", 64'(r_last), 64'd0);
    r_ready = 0;
    pulse_reset();
    chk("rstmid_r_valid", 64'(r_valid), 64'd0);
    chk("rstmid_ar_ready", 64'(ar_ready), 64'd1);
    chk("rstmid_r_id", 64'(r_id), 64'd0);
    ar_valid = 1; ar_id = 6'd10; ar_len = 8'd1;
    step();
    ar_valid = 0;
    read_burst("post_rst", 6'd10, 1);
    r_ready = 0;

    // First-error capture
    pulse_reset();
    ar_valid = 1; ar_id = 6'd7; ar_len = 8'd0;
    step();
    ar_valid = 0;
    r_ready = 1;
    step();
    r_ready = 0;
    aw_valid = 1; aw_id = 6'd4; aw_len = 8'd0;
    step();
    aw_valid = 0;
    w_valid = 1; w_last = 1;
    step();
    w_valid = 0; w_last = 0;
    b_ready = 1;
    step();
    b_ready = 0;
`ifdef DECERR_CAPTURE_EN
    chk("cap_valid", 64'(err_valid), 64'd1);
    chk("cap_id",    64'(err_id),    64'd7);
    chk("cap_write", 64'(err_is_write), 64'd0);
`else
    chk("nocap_valid", 64'(err_valid), 64'd0);
    chk("nocap_id",    64'(err_id),    64'd0);
    chk("nocap_write", 64'(err_is_write), 64'd0);
`endif
    err_clr = 1;
    step();
    err_clr = 0;
    chk("clr_valid", 64'(err_valid), 64'd0);
    chk("clr_id",    64'(err_id),    64'd0);
    chk("clr_write", 64'(err_is_write), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
